// File: rtl/uc_pkg.sv
// Shared definitions for the uc_seq sequencing control unit: FSM state
// encoding, opcode class constants and the raw control bundle.
package uc_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10,
    ST_STEP = 2'b11
  } state_e;

  // Opcode[5:2] classes; 0xxx is the ALU group and is matched on bit 5 alone.
  localparam logic [3:0] OP_LI   = 4'b1000;
  localparam logic [3:0] OP_J    = 4'b1001;
  localparam logic [3:0] OP_JZ   = 4'b1010;
  localparam logic [3:0] OP_JNZ  = 4'b1011;
  localparam logic [3:0] OP_NOP  = 4'b1101;
  localparam logic [3:0] OP_RSV  = 4'b1110;
  localparam logic [3:0] OP_HALT = 4'b1111;

  typedef struct packed {
    logic       s_inc;
    logic       s_inm;
    logic       we3;
    logic       wez;
    logic [2:0] op;
  } ctrl_t;

endpackage

// File: rtl/uc_decode.sv
// Combinational instruction decode: maps (Opcode, z) to ungated datapath
// controls plus flags for the HALT and reserved opcodes.
module uc_decode
  import uc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic       z,
  output ctrl_t      ctrl,
  output logic       is_halt,
  output logic       is_rsv
);

  always_comb begin
    ctrl    = '{s_inc: 1'b1, s_inm: 1'b0, we3: 1'b0, wez: 1'b0, op: 3'b000};
    is_halt = 1'b0;
    is_rsv  = 1'b0;
    if (!opcode[5]) begin
      ctrl.op  = opcode[4:2];
      ctrl.we3 = 1'b1;
      ctrl.wez = 1'b1;
    end else begin
      case (opcode[5:2])
        OP_LI: begin
          ctrl.s_inm = 1'b1;
          ctrl.we3   = 1'b1;
        end
        OP_J:    ctrl.s_inc = 1'b0;
        OP_JZ:   ctrl.s_inc = ~z;
        OP_JNZ:  ctrl.s_inc = z;
        OP_RSV:  is_rsv  = 1'b1;
        OP_HALT: is_halt = 1'b1;
        default: ;  // NOP and unassigned classes fall through as no-ops
      endcase
    end
  end

endmodule

// File: rtl/uc_seq.sv
// Sequencing control unit: boot cycle, run/halt/step debug FSM, write gating,
// sticky illegal-opcode flag and retired-instruction counter.
module uc_seq
  import uc_pkg::*;
#(
  parameter int RW           = 16,
  parameter bit START_HALTED = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [5:0]    Opcode,
  input  logic          z,
  input  logic          run_req,
  input  logic          halt_req,
  input  logic          step_req,
  output logic          s_inc,
  output logic          s_inm,
  output logic          we3,
  output logic          wez,
  output logic [2:0]    Op,
  output logic          ce,
  output logic          halted,
  output logic          illegal,
  output logic [RW-1:0] retired
);

  state_e        state_q, state_d;
  logic          resume_skip_q, resume_skip_d;
  logic          illegal_q, illegal_d;
  logic [RW-1:0] retired_q, retired_d;

  ctrl_t dec;
  logic  is_halt, is_rsv;
  logic  ce_int, active;

  uc_decode u_decode (
    .opcode  (Opcode),
    .z       (z),
    .ctrl    (dec),
    .is_halt (is_halt),
    .is_rsv  (is_rsv)
  );

  always_comb begin
    state_d = state_q;
    ce_int  = 1'b0;
    case (state_q)
      ST_BOOT: state_d = START_HALTED ? ST_HALT : ST_RUN;
      ST_RUN: begin
        // A HALT opcode stops before retiring unless we just resumed past it.
        if (is_halt && !resume_skip_q) begin
          state_d = ST_HALT;
        end else begin
          ce_int = 1'b1;
          if (halt_req) state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        if (halt_req)      state_d = ST_HALT;
        else if (step_req) state_d = ST_STEP;
        else if (run_req)  state_d = ST_RUN;
      end
      ST_STEP: begin
        ce_int  = 1'b1;
        state_d = ST_HALT;
      end
      default: state_d = ST_BOOT;
    endcase

    resume_skip_d = resume_skip_q;
    if (ce_int)                                         resume_skip_d = 1'b0;
    else if (state_q == ST_HALT && state_d != ST_HALT)  resume_skip_d = 1'b1;

    illegal_d = illegal_q | (ce_int & is_rsv);
    retired_d = retired_q + {{(RW-1){1'b0}}, ce_int};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_BOOT;
      resume_skip_q <= 1'b0;
      illegal_q     <= 1'b0;
      retired_q     <= '0;
    end else begin
      state_q       <= state_d;
      resume_skip_q <= resume_skip_d;
      illegal_q     <= illegal_d;
      retired_q     <= retired_d;
    end
  end

  // Decoded selects only drive the datapath in executing states.
  assign active  = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign s_inc   = active ? dec.s_inc : 1'b1;
  assign s_inm   = active ? dec.s_inm : 1'b0;
  assign Op      = active ? dec.op    : 3'b000;
  assign we3     = dec.we3 & ce_int;
  assign wez     = dec.wez & ce_int;
  assign ce      = ce_int;
  assign halted  = (state_q == ST_HALT);
  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_uc_seq.sv
// Self-checking bench for uc_seq: decode table, halt/resume, single-step,
// sticky illegal flag, async reset and retired-counter wrap.
module tb_uc_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  Opcode = 6'b000100;
  logic        z = 1'b0, run_req = 1'b0, halt_req = 1'b0, step_req = 1'b0;
  logic        s_inc, s_inm, we3, wez, ce, halted, illegal;
  logic [2:0]  Op;
  logic [15:0] retired;
  logic        d2_s_inc, d2_s_inm, d2_we3, d2_wez, d2_ce, d2_halted, d2_illegal;
  logic [2:0]  d2_Op;
  logic [15:0] d2_retired;

  always #5 clk = ~clk;

  uc_seq #(.RW(16), .START_HALTED(1'b0)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .z(z),
    .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
    .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .wez(wez), .Op(Op),
    .ce(ce), .halted(halted), .illegal(illegal), .retired(retired)
  );

  uc_seq #(.RW(16), .START_HALTED(1'b1)) dut2 (
    .clk(clk), .reset(reset), .Opcode(Opcode), .z(z),
    .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
    .s_inc(d2_s_inc), .s_inm(d2_s_inm), .we3(d2_we3), .wez(d2_wez), .Op(d2_Op),
    .ce(d2_ce), .halted(d2_halted), .illegal(d2_illegal), .retired(d2_retired)
  );

  typedef struct {
    logic [5:0] opc;
    logic       z;
    logic       s_inc, s_inm, we3, wez;
    logic [2:0] op;
    logic       chk;     // check s_inc/s_inm/Op (not meaningful while stopped)
    logic       ce;
    logic       halted;
  } vec_t;

  vec_t        sb[$];
  vec_t        tbl[10];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_retired = 16'h0000;
  logic        exp_illegal = 1'b0;

  function automatic vec_t mk(logic [5:0] opc, logic zz, logic si, logic sm,
                              logic w3, logic wz, logic [2:0] op, logic chk,
                              logic c, logic h);
    vec_t v;
    v.opc = opc; v.z = zz; v.s_inc = si; v.s_inm = sm; v.we3 = w3; v.wez = wz;
    v.op = op; v.chk = chk; v.ce = c; v.halted = h;
    return v;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, req);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, check at the negedge.
  task automatic step(input vec_t v, input logic rq, input logic hq, input logic sq,
                      input string nm);
    vec_t e;
    Opcode = v.opc; z = v.z; run_req = rq; halt_req = hq; step_req = sq;
    sb.push_back(v);
    @(negedge clk);
    e = sb.pop_front();
    $display("TXN %-10s opc=%b z=%b ce=%b we3=%b wez=%b s_inc=%b s_inm=%b Op=%b halted=%b illegal=%b retired=%0d",
             nm, e.opc, e.z, ce, we3, wez, s_inc, s_inm, Op, halted, illegal, retired);
    cmp({nm, ".ce"}, ce, e.ce);
    cmp({nm, ".we3"}, we3, e.we3);
    cmp({nm, ".wez"}, wez, e.wez);
    cmp({nm, ".halted"}, halted, e.halted);
    if (e.chk) begin
      cmp({nm, ".s_inc"}, s_inc, e.s_inc);
      cmp({nm, ".s_inm"}, s_inm, e.s_inm);
      cmp({nm, ".Op"}, Op, e.op);
    end
    cmp({nm, ".retired"}, retired, exp_retired);
    cmp({nm, ".illegal"}, illegal, exp_illegal);
    if (e.ce) exp_retired++;
    if (e.ce && e.opc[5:2] == 4'b1110) exp_illegal = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout want finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    vec_t nop, alu, hlt_st, hlt_op;
    nop    = mk(6'b110100, 1'b0, 1, 0, 0, 0, 3'b000, 1, 1, 0);
    alu    = mk(6'b000100, 1'b0, 1, 0, 1, 1, 3'b001, 1, 1, 0);
    hlt_st = mk(6'b000100, 1'b0, 1, 0, 0, 0, 3'b000, 0, 0, 1);
    hlt_op = mk(6'b111100, 1'b0, 1, 0, 0, 0, 3'b000, 0, 0, 1);

    tbl[0] = alu;
    tbl[1] = mk(6'b011100, 1'b1, 1, 0, 1, 1, 3'b111, 1, 1, 0);
    tbl[2] = mk(6'b010000, 1'b0, 1, 0, 1, 1, 3'b100, 1, 1, 0);
    tbl[3] = mk(6'b100000, 1'b0, 1, 1, 1, 0, 3'b000, 1, 1, 0);
    tbl[4] = mk(6'b100100, 1'b1, 0, 0, 0, 0, 3'b000, 0, 1, 0);
    tbl[5] = mk(6'b101000, 1'b1, 0, 0, 0, 0, 3'b000, 0, 1, 0);
    tbl[6] = mk(6'b101000, 1'b0, 1, 0, 0, 0, 3'b000, 0, 1, 0);
    tbl[7] = mk(6'b101100, 1'b0, 0, 0, 0, 0, 3'b000, 0, 1, 0);
    tbl[8] = mk(6'b101100, 1'b1, 1, 0, 0, 0, 3'b000, 0, 1, 0);
    tbl[9] = nop;

    // Asynchronous reset assertion between clock edges.
    #2 reset = 1'b0;
    #1;
    cmp("rst.ce", ce, 0);       cmp("rst.we3", we3, 0);   cmp("rst.wez", wez, 0);
    cmp("rst.s_inc", s_inc, 1); cmp("rst.s_inm", s_inm, 0); cmp("rst.Op", Op, 0);
    cmp("rst.halted", halted, 0); cmp("rst.illegal", illegal, 0);
    cmp("rst.retired", retired, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    step(mk(6'b000100, 1'b0, 1, 0, 0, 0, 3'b000, 1, 0, 0), 0, 0, 0, "boot");
    cmp("boot_halted.halted", d2_halted, 1);
    cmp("boot_halted.ce", d2_ce, 0);

    for (int i = 0; i < 10; i++) step(tbl[i], 0, 0, 0, $sformatf("tbl%0d", i));

    step(mk(6'b111000, 1'b0, 1, 0, 0, 0, 3'b000, 1, 1, 0), 0, 0, 0, "rsv");
    step(tbl[0], 0, 0, 0, "post_rsv0");
    step(tbl[3], 0, 0, 0, "post_rsv1");
    cmp("illegal_sticky", illegal, 1);

    step(mk(6'b111100, 1'b0, 1, 0, 0, 0, 3'b000, 0, 0, 0), 0, 0, 0, "halt_op");
    step(hlt_op, 0, 0, 0, "halted0");
    step(hlt_op, 0, 0, 0, "halted1");
    step(hlt_op, 1, 0, 0, "run_req");
    step(mk(6'b111100, 1'b0, 1, 0, 0, 0, 3'b000, 1, 1, 0), 0, 0, 0, "skip");
    step(nop, 0, 0, 0, "run_cont");

    step(nop, 0, 1, 0, "halt_req");
    step(hlt_st, 0, 0, 1, "h_step0");
    step(alu, 0, 0, 1, "step0");
    step(hlt_st, 0, 0, 1, "h_step1");
    step(alu, 0, 0, 0, "step1");
    step(hlt_st, 0, 0, 1, "h_step2");

    // Now in STEP with an ALU opcode; reset mid-cycle must act immediately.
    #2 reset = 1'b0;
    #1;
    cmp("mid_rst.ce", ce, 0);           cmp("mid_rst.we3", we3, 0);
    cmp("mid_rst.retired", retired, 0); cmp("mid_rst.illegal", illegal, 0);
    cmp("mid_rst.halted", halted, 0);   cmp("mid_rst.s_inc", s_inc, 1);
    sb.delete();
    exp_retired = 16'h0000;
    exp_illegal = 1'b0;
    step_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    step(mk(6'b110100, 1'b0, 1, 0, 0, 0, 3'b000, 1, 0, 0), 0, 0, 0, "reboot");
    step(nop, 0, 0, 0, "wrap_run");

    while (exp_retired != 16'hFFFF) begin
      @(posedge clk);
      exp_retired++;
    end
    #1;
    cmp("retired_max", retired, 16'hFFFF);
    step(nop, 0, 0, 0, "wrap_edge");
    step(nop, 0, 0, 0, "wrapped");
    cmp("retired_wrap", retired, 16'h0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uc_seq.md
Name: uc_seq

Overview:
- Sequencing control unit placed directly upstream of the single-cycle microcontroller datapath.
- Consumes the datapath's Opcode (instr[15:10]) and zero flag z.
- Produces s_inc, s_inm, we3, wez and Op, plus a clock-enable ce that gates the PC, register file and z flip-flop at integration.
- Adds a boot cycle, a debug run/halt/single-step state machine, a HALT instruction, a sticky illegal-opcode flag and a retired-instruction counter.

Parameters:
- RW, 16, width of the retired-instruction counter.
- START_HALTED, 0, if 1 the FSM goes BOOT->HALT instead of BOOT->RUN.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- Opcode  input  6  instr[15:10] from the datapath.
- z  input  1  registered zero flag from the datapath.
- run_req  input  1  debug: leave HALT and run, level-sampled.
- halt_req  input  1  debug: stop after the current instruction.
- step_req  input  1  debug: execute exactly one instruction from HALT.
- s_inc  output  1  1 = PC+1, 0 = PC <- instr[9:0].
- s_inm  output  1  immediate select.
- we3  output  1  register-file write enable.
- wez  output  1  zero-flag write enable.
- Op  output  3  ALU operation.
- ce  output  1  datapath state-update enable.
- halted  output  1  1 while in HALT.
- illegal  output  1  sticky: a reserved opcode was executed.
- retired  output  RW  count of cycles with ce=1, wraps modulo 2^RW.

Behaviour:
- Reset (reset=0, async):
  - State BOOT; illegal=0, retired=0, resume_skip=0.
  - Outputs: ce=0, we3=0, wez=0, s_inc=1, s_inm=0, Op=000, halted=0.
- Decode on Opcode[5:2] (combinational, registered state only):
  - 0xxx ALU: Op=Opcode[4:2], we3=1, wez=1, s_inm=0, s_inc=1.
  - 1000 LI: s_inm=1, we3=1, wez=0, Op=000, s_inc=1.
  - 1001 J: s_inc=0, no writes.
  - 1010 JZ: s_inc=~z, no writes.
  - 1011 JNZ: s_inc=z, no writes.
  - 1101 NOP: s_inc=1, no writes.
  - 1110 reserved: behaves as NOP; when ce=1, sets illegal=1 at the clock edge.
  - 1111 HALT: see state rules below.
- Gating: when ce=0, we3=0 and wez=0 regardless of decode.
- States BOOT, RUN, HALT, STEP:
  - BOOT: ce=0 for exactly one cycle, covering the synchronous program-memory read of address 0. Next state is RUN, or HALT if START_HALTED=1.
  - RUN: ce=1, decoded outputs.
    - HALT opcode with resume_skip=0: ce=0, the instruction is not retired, next state HALT.
    - halt_req=1 with a non-HALT opcode: the current instruction completes (ce=1), next state HALT.
  - HALT: ce=0, halted=1.
    - Priority: halt_req > step_req > run_req.
    - step_req=1: next STEP.
    - run_req=1: next RUN.
    - Either exit sets resume_skip=1.
  - STEP: ce=1, decoded outputs; next HALT unconditionally. step_req does not need to be deasserted; one step per HALT->STEP entry.
- resume_skip: while 1, a HALT opcode executes as NOP (ce=1, s_inc=1). It clears on any cycle with ce=1. This guarantees forward progress past the HALT.
- retired: increments on every rising edge with ce=1, including NOP, reserved and skipped HALT. Wraps from all-ones to 0.
- Timing: no extra latency; controls follow Opcode and z within the same cycle.

Decomposition:
- Shared package uc_pkg holds:
  - State encoding: BOOT=2'b00, RUN=2'b01, HALT=2'b10, STEP=2'b11.
  - Opcode[5:2] class constants (OP_LI, OP_J, OP_JZ, OP_JNZ, OP_NOP, OP_RSV, OP_HALT).
- One natural sub-module: uc_decode, purely combinational, mapping (Opcode, z) to raw control signals plus is_halt and is_rsv. uc_seq wraps it with the FSM, gating, counter and flags.

Test Plan:
- Reset release, START_HALTED=0, Opcode=6'b000100 -> cycle 0: ce=0. Cycle 1: ce=1, Op=001, we3=1, wez=1, s_inc=1. retired=1 after that edge.
- RUN, Opcode=6'b101000, z=1 -> s_inc=0. With z=0 -> s_inc=1. Opcode=6'b101100, z=0 -> s_inc=0. No writes in any case.
- RUN, Opcode=6'b111100 -> ce=0, halted=1 next cycle, retired frozen. Pulse run_req with Opcode still 111100 -> one cycle ce=1, s_inc=1 (skip), then RUN continues.
- HALT, step_req held high 3 cycles -> pattern HALT->STEP->HALT->STEP; ce=1 only in STEP cycles; retired +1 per STEP.
- RUN, Opcode=6'b111000 -> illegal=1 from the next edge and stays 1 through later valid opcodes. we3=0. Cleared only by reset=0.
- Mid-STEP async reset=0 -> outputs immediately at reset values (ce=0, retired=0, illegal=0). BOOT follows on release. Also cover retired=16'hFFFF plus one ce cycle -> 0.
